// File: rtl/j1_uart_io.sv
// Memory-mapped UART for the j1 I/O bus: TX FIFO plus serialiser, RX synchroniser, deserialiser
// and a one-byte holding register with valid/overrun/framing flags.
module j1_uart_io #(
  parameter int unsigned CLKFREQ = 12000000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned TXDEPTH = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] dout,
  output logic [15:0] io_din,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned Div  = CLKFREQ / BAUD;
  localparam int unsigned CntW = $clog2(Div);
  localparam int unsigned PtrW = $clog2(TXDEPTH);
  localparam logic [CntW-1:0] DivM1  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(Div / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  logic sel_data, sel_stat, rd_data, rd_stat;
  assign sel_data = mem_addr[12];
  assign sel_stat = mem_addr[13] & ~mem_addr[12];
  assign rd_data  = io_rd & sel_data;
  assign rd_stat  = io_rd & sel_stat;

  logic unused_bits;
  assign unused_bits = ^{mem_addr[15:14], mem_addr[11:0], dout[15:8]};

  // TX FIFO
  logic [7:0]    fifo_mem [TXDEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic full, empty, push, pop;

  assign full  = (count_q == (PtrW + 1)'(TXDEPTH));
  assign empty = (count_q == '0);
  // Fullness is judged before any same-cycle pop, so a pop never makes room for this write.
  assign push  = io_wr & sel_data & ~full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= dout[7:0];
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
    end
  end

  // TX serialiser
  uart_state_e   tx_state_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_tick, tx_busy;

  assign tx_tick = (tx_cnt_q == '0);
  assign pop     = ~empty & ((tx_state_q == StIdle) | ((tx_state_q == StStop) & tx_tick));
  assign tx_busy = ~empty | (tx_state_q != StIdle);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      uart_tx    <= 1'b1;
    end else if (tx_state_q == StIdle) begin
      if (pop) begin
        tx_state_q <= StStart;
        tx_cnt_q   <= DivM1;
        tx_shift_q <= fifo_mem[rd_ptr_q];
        uart_tx    <= 1'b0;
      end
    end else if (!tx_tick) begin
      tx_cnt_q <= tx_cnt_q - CntW'(1);
    end else begin
      tx_cnt_q <= DivM1;
      unique case (tx_state_q)
        StStart: begin
          tx_state_q <= StData;
          tx_bit_q   <= '0;
          uart_tx    <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
        end
        StData: begin
          if (tx_bit_q == 3'd7) begin
            tx_state_q <= StStop;
            uart_tx    <= 1'b1;
          end else begin
            tx_bit_q   <= tx_bit_q + 3'd1;
            uart_tx    <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
        end
        default: begin
          // Chain straight into the next start bit so queued bytes leave without a gap.
          if (pop) begin
            tx_state_q <= StStart;
            tx_shift_q <= fifo_mem[rd_ptr_q];
            uart_tx    <= 1'b0;
          end else begin
            tx_state_q <= StIdle;
          end
        end
      endcase
    end
  end

  // RX synchroniser and deserialiser
  logic [1:0]    rx_sync_q;
  logic          rx_prev_q, rx_s;
  uart_state_e   rx_state_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_done_q, rx_bad_q;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_done_q  <= 1'b0;
      rx_bad_q   <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx};
      rx_prev_q <= rx_s;
      rx_done_q <= 1'b0;
      rx_bad_q  <= 1'b0;
      if (rx_state_q == StIdle) begin
        // Needs a high sample before the low one, so a stuck-low line cannot retrigger.
        if (rx_prev_q && !rx_s) begin
          rx_state_q <= StStart;
          rx_cnt_q   <= HalfM1;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - CntW'(1);
      end else begin
        rx_cnt_q <= DivM1;
        unique case (rx_state_q)
          StStart: begin
            if (rx_s) begin
              rx_state_q <= StIdle;
            end else begin
              rx_state_q <= StData;
              rx_bit_q   <= '0;
            end
          end
          StData: begin
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= StStop;
          end
          default: begin
            rx_state_q <= StIdle;
            rx_done_q  <= rx_s;
            rx_bad_q   <= ~rx_s;
          end
        endcase
      end
    end
  end

  // Holding register and sticky flags
  logic [7:0] rx_hold_q;
  logic       rx_valid_q, rx_ovr_q, frm_err_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_hold_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      if (rx_done_q && (!rx_valid_q || rd_data)) begin
        rx_hold_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end else if (rd_data) begin
        rx_valid_q <= 1'b0;
      end
      rx_ovr_q  <= (rx_done_q & rx_valid_q & ~rd_data) | (rx_ovr_q & ~rd_stat);
      frm_err_q <= rx_bad_q | (frm_err_q & ~rd_stat);
    end
  end

  always_comb begin
    io_din = 16'h0000;
    if (sel_data) begin
      io_din = {8'h00, rx_hold_q};
    end else if (sel_stat) begin
      io_din = {11'b0, frm_err_q, tx_busy, rx_ovr_q, rx_valid_q, ~full};
    end
  end

endmodule

// File: tb/tb_j1_uart_io.sv
// Randomised bench for j1_uart_io: line-level TX decoder and a byte/flag-level RX model.
module tb_j1_uart_io;

  localparam logic [15:0] AddrData = 16'h1000;
  localparam logic [15:0] AddrStat = 16'h2000;
  localparam int Div = 10;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [15:0] dout = 16'h0000;
  logic [15:0] io_din;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // Frames seen on uart_tx: byte, plus 256 if the stop bit was low; and the start cycle.
  int mon_q[$];
  int mon_t[$];

  // RX model state
  logic [7:0] m_hold = 8'h00;
  logic m_valid = 1'b0, m_ovr = 1'b0, m_frm = 1'b0;

  j1_uart_io #(
    .CLKFREQ(1000000),
    .BAUD   (100000),
    .TXDEPTH(4)
  ) dut (
    .clk     (clk),
    .resetq  (resetq),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .mem_addr(mem_addr),
    .dout    (dout),
    .io_din  (io_din),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_status();
    return {11'b0, m_frm, 1'b0, m_ovr, m_valid, 1'b1};
  endfunction

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    mem_addr = addr;
    dout     = data;
    io_wr    = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge clk);
    mem_addr = addr;
    io_rd    = 1'b1;
    #1 data = io_din;
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  // Read with TX idle and compare against the model, then apply the read's side effects.
  task automatic rd_check(input logic [15:0] addr, input string tag);
    logic [15:0] got, exp;
    exp = addr[12] ? {8'h00, m_hold} : (addr[13] ? exp_status() : 16'h0000);
    bus_read(addr, got);
    check_eq(tag, 32'(got), 32'(exp));
    if (addr[12]) m_valid = 1'b0;
    else if (addr[13]) begin
      m_ovr = 1'b0;
      m_frm = 1'b0;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (Div) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (Div) @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    if (!stop_ok) m_frm = 1'b1;
    else if (!m_valid) begin
      m_hold  = b;
      m_valid = 1'b1;
    end else m_ovr = 1'b1;
  endtask

  // TX line decoder, sampling mid-bit
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        int t0;
        logic [7:0] b;
        logic stp;
        t0 = cyc;
        repeat (Div / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (Div) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (Div) @(negedge clk);
        stp = uart_tx;
        mon_q.push_back(stp ? int'(b) : 256 + int'(b));
        mon_t.push_back(t0);
      end
    end
  end

  initial begin
    logic [15:0] rd;
    logic [7:0] bt, lead;
    logic exp_line;
    int exp_q[$];
    int w;

    repeat (3) @(negedge clk);
    resetq = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(AddrStat, rd);
    check_eq("reset_status", 32'(rd), 32'h0001);
    check_eq("reset_tx", 32'(uart_tx), 32'h1);

    // Reset in the middle of a frame (8'hC3, bit2 is low at this point)
    bus_write(AddrData, 16'h00C3);
    repeat (40) @(negedge clk);
    check_eq("pre_reset_tx", 32'(uart_tx), 32'h0);
    #2 resetq = 1'b0;
    #1 check_eq("reset_cut_tx", 32'(uart_tx), 32'h1);
    @(negedge clk);
    resetq = 1'b1;
    repeat (150) @(negedge clk);
    bus_read(AddrStat, rd);
    check_eq("post_reset_status", 32'(rd), 32'h0001);
    mon_q.delete();
    mon_t.delete();

    // Bit-exact single frame
    bus_write(AddrData, 16'h0155);
    mem_addr = AddrStat;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      #1;
      if (k < 10) exp_line = 1'b0;
      else if (k < 90) exp_line = 1'((8'h55 >> ((k - 10) / 10)) & 8'h01);
      else exp_line = 1'b1;
      check_eq($sformatf("tx_line_k%0d", k), 32'(uart_tx), 32'(exp_line));
      check_eq($sformatf("tx_busy_k%0d", k), 32'(io_din[3]), 32'(k < 100));
    end
    repeat (20) @(negedge clk);
    check_eq("single_frame_count", 32'(mon_q.size()), 32'd1);
    if (mon_q.size() > 0) check_eq("single_frame_byte", 32'(mon_q[0]), 32'h55);
    mon_q.delete();
    mon_t.delete();

    // Writes to STATUS never reach the line
    bus_write(AddrStat, 16'h00FF);
    repeat (120) @(negedge clk);
    check_eq("status_write_ignored", 32'(mon_q.size()), 32'd0);

    // Lead byte in flight, then five back-to-back writes: FIFO holds four, fifth dropped
    lead = 8'($urandom_range(0, 255));
    exp_q.delete();
    exp_q.push_back(int'(lead));
    bus_write(AddrData, {8'($urandom), lead});
    repeat (20) @(negedge clk);
    @(negedge clk);
    mem_addr = AddrData;
    io_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bt = 8'($urandom);
      dout = {8'($urandom), bt};
      if (i < 4) exp_q.push_back(int'(bt));
      @(negedge clk);
    end
    io_wr = 1'b0;
    mem_addr = AddrStat;
    #1;
    check_eq("fifo_full_ready", 32'(io_din[0]), 32'h0);
    check_eq("fifo_full_busy", 32'(io_din[3]), 32'h1);
    // Lead frame started 2 clocks after its write and lasts 100; first pop frees a slot then
    w = 0;
    while (io_din[0] == 1'b0 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    check_eq("ready_rise_cycle", 32'(w), 32'd75);
    repeat (450) @(negedge clk);
    check_eq("burst_frame_count", 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check_eq($sformatf("burst_byte%0d", i), 32'(mon_q[i]), 32'(exp_q[i]));
      if (i > 0)
        check_eq($sformatf("burst_gap%0d", i), 32'(mon_t[i] - mon_t[i-1]), 32'd100);
    end
    mon_q.delete();
    mon_t.delete();

    // RX: single byte, read out, re-read
    send_rx(8'hA5, 1'b1);
    rd_check(AddrStat, "rx_status_valid");
    rd_check(AddrData, "rx_data_a5");
    rd_check(AddrData, "rx_data_reread");
    rd_check(AddrStat, "rx_status_cleared");

    // Overrun keeps the first byte
    send_rx(8'hA5, 1'b1);
    send_rx(8'h3C, 1'b1);
    rd_check(AddrStat, "ovr_status_set");
    rd_check(AddrStat, "ovr_status_clear");
    rd_check(16'h3000, "ovr_data_both_sel");

    // Framing error leaves rx_valid alone
    send_rx(8'h96, 1'b1);
    send_rx(8'h5A, 1'b0);
    rd_check(AddrStat, "frm_status_set");
    rd_check(AddrStat, "frm_status_clear");
    rd_check(AddrData, "frm_data_kept");

    // Short glitch on idle line
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    rd_check(AddrStat, "glitch_no_flags");
    send_rx(8'($urandom), 1'b1);
    rd_check(AddrData, "after_glitch_data");

    // Random RX traffic and reads
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 4))
        0, 1: send_rx(8'($urandom), 1'b1);
        2: send_rx(8'($urandom), 1'b0);
        3: rd_check(AddrData, $sformatf("rand_data%0d", i));
        default: rd_check(AddrStat, $sformatf("rand_stat%0d", i));
      endcase
    end
    rd_check(AddrStat, "rand_final_stat");
    rd_check(AddrData, "rand_final_data");
    rd_check(16'h0400, "unmapped_read");
    check_eq("rx_never_echoed", 32'(mon_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
